// File: rtl/io_led_switch_ctrl_pkg.sv
// Shared constants for the LED/switch I/O responder.
// Holds the sub-register offsets decoded from the low address bits and the
// I/O base nibbles that the upstream address decoder uses to raise the chip
// selects.
package io_led_switch_ctrl_pkg;

  localparam int unsigned LED_W = 24;
  localparam int unsigned SW_W  = 24;

  // Sub-register offsets (ioaddr = addr[1:0])
  localparam logic [1:0] LED_LO  = 2'b00;
  localparam logic [1:0] LED_HI  = 2'b10;
  localparam logic [1:0] SW_LO   = 2'b00;
  localparam logic [1:0] SW_HI   = 2'b10;
  localparam logic [1:0] SW_FLAG = 2'b01;

  // I/O base nibbles shared with the address decoder
  localparam logic [3:0] LED_BASE = 4'h6;
  localparam logic [3:0] SW_BASE  = 4'h7;

endpackage

// File: rtl/io_debounce.sv
// Switch input conditioner: two-flop synchroniser followed by a single shared
// debounce counter for the whole vector.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   din         - raw asynchronous switch levels
//   stable      - debounced switch vector
//   accept      - high in the cycle whose clock edge loads a new stable value
module io_debounce
  import io_led_switch_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH           = SW_W,
  parameter int unsigned DEBOUNCE_CYCLES = 230000,
  parameter int unsigned CNT_W           = 18
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] stable,
  output logic             accept
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sw_s;
  logic [WIDTH-1:0] sw_prev_q;
  logic [WIDTH-1:0] sw_q, sw_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sw_s      <= '0;
      sw_prev_q <= '0;
      sw_q      <= '0;
      cnt_q     <= '0;
    end else begin
      sync1_q   <= din;
      sw_s      <= sync1_q;
      sw_prev_q <= sw_s;
      sw_q      <= sw_d;
      cnt_q     <= cnt_d;
    end
  end

  // The counter only runs while the synchronised pattern differs from the
  // stable one and has not moved since the previous cycle; any movement
  // restarts the window. Reaching CNT_LAST loads and clears, so it never wraps.
  always_comb begin
    cnt_d  = '0;
    sw_d   = sw_q;
    accept = 1'b0;
    if (sw_s == sw_q) begin
      cnt_d = '0;
    end else if (sw_s != sw_prev_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      sw_d   = sw_s;
      accept = 1'b1;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign stable = sw_q;

endmodule

// File: rtl/io_led_switch_ctrl.sv
// Peripheral-side responder for the CPU I/O port: 24 LED registers written by
// I/O stores, and 24 debounced switches plus a new-data flag read by I/O loads.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   ioRead, ioWrite   - I/O strobes from the controller
//   LEDCtrl           - LED chip select
//   SwitchCtrl        - switch chip select
//   ioaddr            - sub-register select (addr[1:0])
//   io_wdata          - write data (low half of the CPU write bus)
//   io_rdata          - read data, zero when the switch block is not read
//   led               - LED drive, 1 = lit
//   switch_i          - raw asynchronous switch levels
module io_led_switch_ctrl
  import io_led_switch_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 230000,
  parameter int unsigned CNT_W           = 18
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ioRead,
  input  logic             ioWrite,
  input  logic             LEDCtrl,
  input  logic             SwitchCtrl,
  input  logic [1:0]       ioaddr,
  input  logic [15:0]      io_wdata,
  output logic [15:0]      io_rdata,
  output logic [LED_W-1:0] led,
  input  logic [SW_W-1:0]  switch_i
);

  logic [LED_W-1:0] led_q;
  logic             new_flag_q;
  logic [SW_W-1:0]  sw_q;
  logic             accept;
  logic             wr_en;
  logic             rd_en;

  assign wr_en = ioWrite && LEDCtrl;
  assign rd_en = ioRead && SwitchCtrl;

  io_debounce #(
    .WIDTH           (SW_W),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_debounce (
    .clk    (clk),
    .rst_n  (rst_n),
    .din    (switch_i),
    .stable (sw_q),
    .accept (accept)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q      <= '0;
      new_flag_q <= 1'b0;
    end else begin
      if (wr_en) begin
        case (ioaddr)
          LED_LO:  led_q[15:0]  <= io_wdata;
          LED_HI:  led_q[23:16] <= io_wdata[7:0];
          default: ;
        endcase
      end
      // A fresh accept must not be lost to a read racing it on the same edge.
      if (accept) begin
        new_flag_q <= 1'b1;
      end else if (rd_en && (ioaddr == SW_FLAG)) begin
        new_flag_q <= 1'b0;
      end
    end
  end

  // Combinational from registered state so a single-cycle load sees data.
  always_comb begin
    io_rdata = 16'h0;
    if (rd_en) begin
      case (ioaddr)
        SW_LO:   io_rdata = sw_q[15:0];
        SW_HI:   io_rdata = {8'h00, sw_q[23:16]};
        SW_FLAG: io_rdata = {15'h0, new_flag_q};
        default: io_rdata = 16'h0;
      endcase
    end
  end

  assign led = led_q;

endmodule

// File: tb/tb_io_led_switch_ctrl.sv
// Bench for io_led_switch_ctrl with DEBOUNCE_CYCLES = 4 (accept latency 7).
module tb_io_led_switch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ioRead = 1'b0;
  logic        ioWrite = 1'b0;
  logic        LEDCtrl = 1'b0;
  logic        SwitchCtrl = 1'b0;
  logic [1:0]  ioaddr = 2'b00;
  logic [15:0] io_wdata = 16'h0;
  logic [15:0] io_rdata;
  logic [23:0] led;
  logic [23:0] switch_i = 24'h0;

  always #5 clk = ~clk;

  io_led_switch_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (18)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ioRead     (ioRead),
    .ioWrite    (ioWrite),
    .LEDCtrl    (LEDCtrl),
    .SwitchCtrl (SwitchCtrl),
    .ioaddr     (ioaddr),
    .io_wdata   (io_wdata),
    .io_rdata   (io_rdata),
    .led        (led),
    .switch_i   (switch_i)
  );

  typedef struct {
    string       name;
    logic [23:0] val;
  } exp_t;

  typedef struct {
    string       name;
    logic        wr;
    logic        cs;
    logic [1:0]  addr;
    logic [15:0] wdata;
    logic [23:0] exp_led;
  } led_vec_t;

  exp_t     sb_q[$];
  led_vec_t vecs[7];
  int       n_checks = 0;
  int       n_pass = 0;

  task automatic sb_push(input string name, input logic [23:0] val);
    exp_t e;
    e.name = name;
    e.val  = val;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input logic [23:0] act);
    exp_t e;
    n_checks++;
    if (sb_q.size() == 0) begin
      $display("FAIL scoreboard_empty actual=%h", act);
    end else begin
      e = sb_q.pop_front();
      if (act === e.val) n_pass++;
      else $display("FAIL %s actual=%h required=%h", e.name, act, e.val);
    end
  endtask

  task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
    sb_push(name, exp);
    sb_check(act);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{"led_lo_write",  1'b1, 1'b1, 2'b00, 16'hA5C3, 24'h00A5C3};
    vecs[1] = '{"led_hi_write",  1'b1, 1'b1, 2'b10, 16'h1234, 24'h34A5C3};
    vecs[2] = '{"led_addr01_ign", 1'b1, 1'b1, 2'b01, 16'hFFFF, 24'h34A5C3};
    vecs[3] = '{"led_addr11_ign", 1'b1, 1'b1, 2'b11, 16'hFFFF, 24'h34A5C3};
    vecs[4] = '{"led_no_cs",     1'b1, 1'b0, 2'b00, 16'h0000, 24'h34A5C3};
    vecs[5] = '{"led_no_strobe", 1'b0, 1'b1, 2'b00, 16'h0000, 24'h34A5C3};
    vecs[6] = '{"led_hi_rewrite", 1'b1, 1'b1, 2'b10, 16'h55AB, 24'hABA5C3};

    // Power-on reset, with a switch read pending to show io_rdata is forced 0
    #1 rst_n = 1'b0;
    ioRead = 1'b1; SwitchCtrl = 1'b1; ioaddr = 2'b00;
    #2;
    chk("reset_led", led, 24'h0);
    chk("reset_rdata", {8'h0, io_rdata}, 24'h0);
    ioRead = 1'b0; SwitchCtrl = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // LED writes, table driven
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      ioWrite  = vecs[i].wr;
      LEDCtrl  = vecs[i].cs;
      ioaddr   = vecs[i].addr;
      io_wdata = vecs[i].wdata;
      sb_push(vecs[i].name, vecs[i].exp_led);
      tick();
      sb_check(led);
    end
    @(negedge clk);
    ioWrite = 1'b0; LEDCtrl = 1'b0;

    // Debounce latency: exactly 7 edges from the raw change
    switch_i = 24'h00F00F;
    ioRead = 1'b1; SwitchCtrl = 1'b1; ioaddr = 2'b00;
    for (int k = 1; k <= 7; k++) begin
      sb_push($sformatf("sw_lo_edge%0d", k), (k == 7) ? 24'h00F00F : 24'h0);
      tick();
      sb_check({8'h0, io_rdata});
    end
    ioaddr = 2'b10; #1;
    chk("sw_hi_read", {8'h0, io_rdata}, 24'h0);
    ioaddr = 2'b11; #1;
    chk("sw_addr11_read", {8'h0, io_rdata}, 24'h0);
    ioaddr = 2'b01; #1;
    chk("flag_set", {8'h0, io_rdata}, 24'h1);
    tick();
    chk("flag_cleared", {8'h0, io_rdata}, 24'h0);
    tick();
    chk("flag_reread", {8'h0, io_rdata}, 24'h0);

    // Clearing read on the same edge as an accept: set wins
    ioaddr = 2'b00;
    switch_i = 24'h00F00E;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk($sformatf("sw_hold_edge%0d", k), {8'h0, io_rdata}, 24'h00F00F);
    end
    ioaddr = 2'b01;
    tick();
    chk("flag_set_wins", {8'h0, io_rdata}, 24'h1);
    ioaddr = 2'b00; #1;
    chk("sw_lo_after_race", {8'h0, io_rdata}, 24'h00F00E);
    ioaddr = 2'b01;
    tick();
    chk("flag_clear_after_race", {8'h0, io_rdata}, 24'h0);

    // Bounce rejection: bit0 toggles every 2 cycles for 20 cycles, then holds 1
    for (int p = 0; p < 10; p++) begin
      switch_i[0] = (p % 2 == 0) ? 1'b1 : 1'b0;
      for (int c = 0; c < 2; c++) begin
        tick();
        chk($sformatf("bounce_flag_p%0d", p), {8'h0, io_rdata}, 24'h0);
      end
    end
    switch_i[0] = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      sb_push($sformatf("settle_flag_edge%0d", k), (k == 7) ? 24'h1 : 24'h0);
      tick();
      sb_check({8'h0, io_rdata});
    end
    tick();
    chk("settle_flag_cleared", {8'h0, io_rdata}, 24'h0);
    ioaddr = 2'b00; #1;
    chk("settle_sw_lo", {8'h0, io_rdata}, 24'h00F00F);

    // Idle reads
    SwitchCtrl = 1'b0; #1;
    chk("idle_no_cs", {8'h0, io_rdata}, 24'h0);
    SwitchCtrl = 1'b1; ioRead = 1'b0; #1;
    chk("idle_no_strobe", {8'h0, io_rdata}, 24'h0);

    // Mid-run asynchronous reset with all LEDs lit and a live read
    @(negedge clk);
    ioWrite = 1'b1; LEDCtrl = 1'b1; ioaddr = 2'b00; io_wdata = 16'hFFFF;
    @(negedge clk);
    ioaddr = 2'b10; io_wdata = 16'h00FF;
    @(negedge clk);
    ioWrite = 1'b0; LEDCtrl = 1'b0;
    chk("led_all_lit", led, 24'hFFFFFF);
    ioRead = 1'b1; SwitchCtrl = 1'b1; ioaddr = 2'b00;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_reset_led", led, 24'h0);
    chk("async_reset_rdata", {8'h0, io_rdata}, 24'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      sb_push($sformatf("reaccept_edge%0d", k), (k == 7) ? 24'h00F00F : 24'h0);
      tick();
      sb_check({8'h0, io_rdata});
    end
    ioaddr = 2'b01; #1;
    chk("reaccept_flag", {8'h0, io_rdata}, 24'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/io_led_switch_ctrl.md
Name: io_led_switch_ctrl

Overview:
- Peripheral-side responder for the CPU I/O port.
- Accepts the LED and switch chip selects, low address bits and 16-bit write data from the CPU memory/IO steering logic.
- Holds the 24 board LEDs in registers.
- Synchronises and debounces the 24 board switches, and returns 16-bit read data for I/O loads.
- Sits between the CPU top level and the board pins.

Parameters:
DEBOUNCE_CYCLES, 230000, clock cycles a new switch pattern must stay constant before it is accepted (10 ms at 23 MHz)
CNT_W, 18, width of the debounce counter; must hold DEBOUNCE_CYCLES

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
ioRead  input  1  I/O read strobe from controller
ioWrite  input  1  I/O write strobe from controller
LEDCtrl  input  1  LED chip select, active high
SwitchCtrl  input  1  switch chip select, active high
ioaddr  input  2  addr[1:0] of the I/O access, selects the sub-register
io_wdata  input  16  write data from CPU, low half of the write bus
io_rdata  output  16  read data to CPU
led  output  24  board LED drive, 1 = lit
switch_i  input  24  raw board switch levels, asynchronous

Behaviour:
- One clock, single edge. rst_n is asynchronous, active low. All registers clear on assertion; release is synchronous to clk.
- Reset values:
  - led = 24'h0, io_rdata = 16'h0.
  - Synchroniser flops = 0, stable switch vector = 0, debounce counter = 0, new_flag = 0.
- LED write, on the rising edge when ioWrite && LEDCtrl:
  - ioaddr 2'b00: led[15:0] <= io_wdata.
  - ioaddr 2'b10: led[23:16] <= io_wdata[7:0].
  - ioaddr 01/11: ignored.
  - LED output is visible the cycle after the write edge. Without the write strobe, led holds.
- Switch input path:
  - Two-flop synchroniser on switch_i produces sw_s.
  - Debounce (single shared counter for the whole vector, compare against stable vector sw_q):
    - sw_s == sw_q: counter <= 0.
    - sw_s != sw_q and sw_s differs from its previous-cycle value: counter <= 0 (restart).
    - Otherwise counter increments. When counter == DEBOUNCE_CYCLES-1: sw_q <= sw_s, counter <= 0, new_flag <= 1.
  - Raw-edge to sw_q latency is 2 + DEBOUNCE_CYCLES + 1 cycles.
  - Counter never wraps; it saturates by construction at the accept point.
- Read, combinational from registered state so a single-cycle load sees data in the same cycle. When ioRead && SwitchCtrl:
  - ioaddr 00: io_rdata = sw_q[15:0].
  - ioaddr 10: io_rdata = {8'h00, sw_q[23:16]}.
  - ioaddr 01: io_rdata = {15'h0, new_flag}.
  - ioaddr 11: io_rdata = 16'h0.
  - When not (ioRead && SwitchCtrl): io_rdata = 16'h0, never Z.
- new_flag handshake:
  - Clears on the edge of a read at ioaddr 01.
  - If an accept and a clearing read hit the same edge, set wins and the flag stays 1.
  - Reads at other offsets do not touch it.
- LEDCtrl and SwitchCtrl both asserted is illegal upstream; the block still performs both actions independently.
- Reset mid-debounce: counter and sw_q return to 0. After release, the current switch pattern is re-accepted after the full latency.

Decomposition:
- Shared package/header holds the sub-register offsets: LED_LO=2'b00, LED_HI=2'b10, SW_LO=2'b00, SW_HI=2'b10, SW_FLAG=2'b01.
- The same package holds the I/O base nibbles shared with the address decoder: LED 4'h6, switch 4'h7.
- One natural sub-module: io_debounce (synchroniser + counter + stable register + accept pulse), parameterised by width and DEBOUNCE_CYCLES.
- The top level keeps the LED registers, read mux and new_flag.

Test Plan:
- DEBOUNCE_CYCLES=4 for all tests.
- Reset: assert rst_n=0 mid-run with led=24'hFFFFFF -> led=0, io_rdata=0 immediately, asynchronously.
- LED writes:
  - ioWrite=1, LEDCtrl=1, ioaddr=00, io_wdata=16'hA5C3 -> led[15:0]=16'hA5C3 next cycle.
  - Then ioaddr=10, io_wdata=16'h1234 -> led=24'h34A5C3.
  - ioaddr=01 write -> led unchanged.
- Switch debounce: switch_i=24'h00F00F held -> sw_q updates exactly 7 cycles after change. Then ioRead=1, SwitchCtrl=1, ioaddr=00 -> io_rdata=16'hF00F; ioaddr=10 -> 16'h0000.
- Bounce rejection: toggle switch_i bit0 every 2 cycles for 20 cycles, then hold 1 -> no accept during toggling; new_flag=0 until 7 cycles after the last toggle.
- Flag handshake:
  - Accept -> read ioaddr=01 returns 16'h0001; flag clears next cycle; re-read returns 0.
  - Clearing read on the same edge as an accept -> flag remains 1.
- Idle read: ioRead=1, SwitchCtrl=0 -> io_rdata=16'h0000.
